// File: rtl/cordic_req_arbiter.sv
// Round-robin front end that shares one cordic_sin_cos core between N_REQ requesters.
// Define CORDIC_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns rsp_err on a stalled core.
module cordic_req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_angle,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_sine,
  output logic [15:0]          rsp_cosine,
  output logic                 rsp_err,
  output logic                 core_start,
  output logic [15:0]          core_angle,
  input  logic [15:0]          core_sine,
  input  logic [15:0]          core_cosine,
  input  logic                 core_done
);

  typedef enum logic [2:0] {IDLE, NORM, ISSUE, WAIT, RESP} state_e;

  state_e          state_q;
  logic [ID_W-1:0] rrPtr_q, grantId_q, rspId_q;
  logic [15:0]     workAngle_q, coreAngle_q, rspSine_q, rspCosine_q;
  logic [2:0]      normK_q;
  logic            blankDone_q, coreStart_q, rspValid_q;

  logic            winFound;
  logic [ID_W-1:0] winIdx;
  logic [15:0]     winAngle;
  logic [16:0]     normThresh;
  logic [15:0]     normNext;

  // Round-robin search: indices above rrPtr_q first, then wrap to the low ones.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    winAngle = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!winFound && req[i] && (i > int'(rrPtr_q))) begin
        winFound = 1'b1;
        winIdx   = ID_W'(i);
        winAngle = req_angle[16*i +: 16];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!winFound && req[i] && (i <= int'(rrPtr_q))) begin
        winFound = 1'b1;
        winIdx   = ID_W'(i);
        winAngle = req_angle[16*i +: 16];
      end
    end
  end

  // Ack must land in the same IDLE cycle the winner is chosen; reset masks it.
  always_comb begin
    ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = !reset && (state_q == IDLE) && winFound && (int'(winIdx) == i);
    end
  end

  always_comb begin
    normThresh = 17'd360 << normK_q;
    normNext   = workAngle_q;
    if ({1'b0, workAngle_q} >= normThresh) begin
      normNext = workAngle_q - normThresh[15:0];
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdCount_q;
  logic            rspErr_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rrPtr_q     <= ID_W'(N_REQ - 1);
      grantId_q   <= '0;
      rspId_q     <= '0;
      workAngle_q <= '0;
      coreAngle_q <= '0;
      rspSine_q   <= '0;
      rspCosine_q <= '0;
      normK_q     <= '0;
      blankDone_q <= 1'b0;
      coreStart_q <= 1'b0;
      rspValid_q  <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      wdCount_q   <= '0;
      rspErr_q    <= 1'b0;
`endif
    end else begin
      coreStart_q <= 1'b0;
      rspValid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winFound) begin
            grantId_q   <= winIdx;
            rrPtr_q     <= winIdx;
            workAngle_q <= winAngle;
            normK_q     <= 3'd7;
            state_q     <= NORM;
          end
        end
        NORM: begin
          workAngle_q <= normNext;
          if (normK_q == 3'd0) begin
            coreAngle_q <= normNext;
            coreStart_q <= 1'b1;
            state_q     <= ISSUE;
          end else begin
            normK_q <= normK_q - 3'd1;
          end
        end
        ISSUE: begin
          blankDone_q <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
          wdCount_q   <= '0;
`endif
          state_q     <= WAIT;
        end
        WAIT: begin
          // The core still shows the previous done level during the first WAIT cycle.
          if (blankDone_q && core_done) begin
            rspSine_q   <= core_sine;
            rspCosine_q <= core_cosine;
            rspId_q     <= grantId_q;
            rspValid_q  <= 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
            rspErr_q    <= 1'b0;
`endif
            state_q     <= RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
          end else if (wdCount_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            rspSine_q   <= '0;
            rspCosine_q <= '0;
            rspId_q     <= grantId_q;
            rspValid_q  <= 1'b1;
            rspErr_q    <= 1'b1;
            state_q     <= RESP;
`endif
          end else begin
            blankDone_q <= 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
            wdCount_q   <= wdCount_q + 1'b1;
`endif
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  assign rsp_err = rspErr_q;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES != 0);
  assign rsp_err       = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign rsp_valid  = rspValid_q;
  assign rsp_id     = rspId_q;
  assign rsp_sine   = rspSine_q;
  assign rsp_cosine = rspCosine_q;
  assign core_start = coreStart_q;
  assign core_angle = coreAngle_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter with a small behavioural stand-in for the cordic core.
// Honours CORDIC_ARB_TIMEOUT_EN the same way as the design.
module tb_cordic_req_arbiter;

  localparam int N_REQ      = 4;
  localparam int ID_W       = 2;
  localparam int TIMEOUT    = 64;
  localparam int CORE_LAT   = 3;
  // ack cycle -> rsp_valid: 8 NORM + 1 ISSUE + 5 WAIT (blank + CORE_LAT + done) + 1
  localparam int NORMAL_LAT = 15;

  logic                clk;
  logic                reset;
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] reqAngle;
  logic [N_REQ-1:0]    ack;
  logic                busy;
  logic                rspValid;
  logic [ID_W-1:0]     rspId;
  logic [15:0]         rspSine;
  logic [15:0]         rspCosine;
  logic                rspErr;
  logic                coreStart;
  logic [15:0]         coreAngle;
  logic [15:0]         coreSine;
  logic [15:0]         coreCosine;
  logic                coreDone;

  int checks   = 0;
  int failures = 0;
  int grantSeq[8];
  logic coreHang = 1'b0;
  logic monAck2  = 1'b0;
  int   ack2Count = 0;

  cordic_req_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_angle  (reqAngle),
    .ack        (ack),
    .busy       (busy),
    .rsp_valid  (rspValid),
    .rsp_id     (rspId),
    .rsp_sine   (rspSine),
    .rsp_cosine (rspCosine),
    .rsp_err    (rspErr),
    .core_start (coreStart),
    .core_angle (coreAngle),
    .core_sine  (coreSine),
    .core_cosine(coreCosine),
    .core_done  (coreDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core results for the angles the vectors use; other angles get a recognisable pattern.
  function automatic logic [15:0] modelSin(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h0000;
      16'd15:  return 16'h1090;
      16'd30:  return 16'h2000;
      16'd180: return 16'h0000;
      default: return a ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [15:0] modelCos(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h4000;
      16'd15:  return 16'h3DD1;
      16'd30:  return 16'h376D;
      16'd180: return 16'hC006;
      default: return ~a;
    endcase
  endfunction

  // Core stand-in: done stays high until one cycle after start, then rises CORE_LAT cycles later.
  logic        corePend;
  int          coreCnt;
  logic [15:0] coreLatched;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      corePend    <= 1'b0;
      coreCnt     <= 0;
      coreDone    <= 1'b0;
      coreSine    <= '0;
      coreCosine  <= '0;
      coreLatched <= '0;
    end else if (coreStart) begin
      corePend    <= 1'b1;
      coreLatched <= coreAngle;
    end else if (corePend) begin
      corePend <= 1'b0;
      coreDone <= 1'b0;
      coreCnt  <= CORE_LAT;
    end else if (coreCnt != 0 && !coreHang) begin
      coreCnt <= coreCnt - 1;
      if (coreCnt == 1) begin
        coreDone   <= 1'b1;
        coreSine   <= modelSin(coreLatched);
        coreCosine <= modelCos(coreLatched);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (monAck2 && ack[2]) ack2Count++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Raise req[idx] at a falling edge, wait for its ack, drop req one cycle later.
  task automatic applyStimulus(input int idx, input logic [15:0] angle);
    int   waitCyc;
    logic seen;
    seen    = 1'b0;
    waitCyc = 0;
    @(negedge clk);
    reqAngle[16*idx +: 16] = angle;
    req[idx] = 1'b1;
    while (!seen && waitCyc < 200) begin
      #1;
      if (ack[idx]) seen = 1'b1;
      else begin
        @(negedge clk);
        waitCyc++;
      end
    end
    checkOutput($sformatf("ack%0d_seen", idx), 32'(seen), 32'd1);
    if (seen) checkOutput($sformatf("ack%0d_onehot", idx), 32'(ack), 32'(1 << idx));
    @(negedge clk);
    req[idx] = 1'b0;
  endtask

  // Called on the falling edge one cycle after the ack cycle.
  task automatic waitResponse(input int expId, input logic [15:0] expAngle, input logic [15:0] expSine,
                              input logic [15:0] expCos, input logic expErr, input int expLat);
    int          lat;
    logic        startSeen;
    logic [15:0] issued;
    lat       = 1;
    startSeen = 1'b0;
    issued    = '0;
    while (!rspValid && lat < 300) begin
      if (coreStart) begin
        startSeen = 1'b1;
        issued    = coreAngle;
      end
      @(negedge clk);
      lat++;
    end
    checkOutput("rsp_valid_seen", 32'(rspValid), 32'd1);
    checkOutput("rsp_latency", 32'(lat), 32'(expLat));
    checkOutput("core_start_seen", 32'(startSeen), 32'd1);
    checkOutput("core_angle_issued", 32'(issued), 32'(expAngle));
    checkOutput("core_angle_held", 32'(coreAngle), 32'(expAngle));
    checkOutput("rsp_id", 32'(rspId), 32'(expId));
    checkOutput("rsp_sine", 32'(rspSine), 32'(expSine));
    checkOutput("rsp_cosine", 32'(rspCosine), 32'(expCos));
    checkOutput("rsp_err", 32'(rspErr), 32'(expErr));
    @(negedge clk);
    checkOutput("rsp_valid_one_cycle", 32'(rspValid), 32'd0);
    checkOutput("rsp_sine_stable", 32'(rspSine), 32'(expSine));
  endtask

  // Record the indices of the next n acks; returns on the falling edge after the last one.
  task automatic collectGrants(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      #1;
      if (ack != '0) begin
        for (int b = 0; b < N_REQ; b++) if (ack[b]) grantSeq[got] = b;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("grants_collected", 32'(got), 32'(n));
  endtask

  task automatic waitIdle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("returned_to_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int          idx;
    logic [15:0] angle;
    logic [15:0] expAngle;
    logic [15:0] expSine;
    logic [15:0] expCos;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    vecs[0] = '{0, 16'd30,    16'd30,  16'h2000, 16'h376D};
    vecs[1] = '{1, 16'd390,   16'd30,  16'h2000, 16'h376D};
    vecs[2] = '{2, 16'd720,   16'd0,   16'h0000, 16'h4000};
    vecs[3] = '{3, 16'd65535, 16'd15,  16'h1090, 16'h3DD1};
    vecs[4] = '{0, 16'd180,   16'd180, 16'h0000, 16'hC006};
    vecs[5] = '{1, 16'd360,   16'd0,   16'h0000, 16'h4000};
    vecs[6] = '{2, 16'd359,   16'd359, 16'h5B3D, 16'hFE98};
    vecs[7] = '{3, 16'd46439, 16'd359, 16'h5B3D, 16'hFE98};
    vecs[8] = '{0, 16'd46080, 16'd0,   16'h0000, 16'h4000};

    reset    = 1'b1;
    req      = 4'hF;
    reqAngle = {16'd180, 16'd720, 16'd390, 16'd30};
    repeat (3) @(negedge clk);

    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset_rsp_id", 32'(rspId), 32'd0);
    checkOutput("reset_rsp_sine", 32'(rspSine), 32'd0);
    checkOutput("reset_rsp_cosine", 32'(rspCosine), 32'd0);
    checkOutput("reset_rsp_err", 32'(rspErr), 32'd0);
    checkOutput("reset_core_start", 32'(coreStart), 32'd0);
    checkOutput("reset_core_angle", 32'(coreAngle), 32'd0);

    // All four held from reset: rotation starts at 0 because the pointer resets to 3.
    reset = 1'b0;
    collectGrants(5);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("rr_grant%0d", i), 32'(grantSeq[i]), 32'(i % 4));
    req = 4'b1000;
    collectGrants(1);
    checkOutput("rr_grant_to3", 32'(grantSeq[0]), 32'd3);
    req = 4'b1010;
    collectGrants(2);
    checkOutput("rr_after3_first", 32'(grantSeq[0]), 32'd1);
    checkOutput("rr_after3_second", 32'(grantSeq[1]), 32'd3);
    req = 4'b0000;
    waitIdle();

    for (int i = 0; i < 9; i++) begin
      $display("[TB] vector %0d: requester %0d angle %0d", i, vecs[i].idx, vecs[i].angle);
      applyStimulus(vecs[i].idx, vecs[i].angle);
      waitResponse(vecs[i].idx, vecs[i].expAngle, vecs[i].expSine, vecs[i].expCos, 1'b0, NORMAL_LAT);
    end

    // Requester 2 asks while busy and withdraws before the next IDLE.
    applyStimulus(0, 16'd30);
    reqAngle[16*2 +: 16] = 16'd100;
    req[2]  = 1'b1;
    monAck2 = 1'b1;
    fork
      waitResponse(0, 16'd30, 16'h2000, 16'h376D, 1'b0, NORMAL_LAT);
      begin
        repeat (5) @(negedge clk);
        req[2] = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    monAck2 = 1'b0;
    checkOutput("withdrawn_ack2_count", 32'(ack2Count), 32'd0);

    // Reset in the middle of WAIT abandons the transaction.
    applyStimulus(1, 16'd30);
    begin
      int cyc;
      cyc = 0;
      while (!coreStart && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("midreset_start_seen", 32'(coreStart), 32'd1);
    end
    repeat (2) @(negedge clk);
    checkOutput("midreset_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_ack", 32'(ack), 32'd0);
    checkOutput("midreset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("midreset_core_start", 32'(coreStart), 32'd0);
    checkOutput("midreset_core_angle", 32'(coreAngle), 32'd0);
    checkOutput("midreset_rsp_sine", 32'(rspSine), 32'd0);
    checkOutput("midreset_rsp_cosine", 32'(rspCosine), 32'd0);
    checkOutput("midreset_rsp_id", 32'(rspId), 32'd0);
    begin
      int sawRsp;
      sawRsp = 0;
      repeat (3) begin
        @(negedge clk);
        if (rspValid) sawRsp++;
      end
      reset = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (rspValid) sawRsp++;
      end
      checkOutput("midreset_no_response", 32'(sawRsp), 32'd0);
    end
    applyStimulus(3, 16'd390);
    waitResponse(3, 16'd30, 16'h2000, 16'h376D, 1'b0, NORMAL_LAT);

    // Core never completes.
    coreHang = 1'b1;
    applyStimulus(0, 16'd30);
`ifdef CORDIC_ARB_TIMEOUT_EN
    waitResponse(0, 16'd30, 16'h0000, 16'h0000, 1'b1, 8 + 1 + TIMEOUT + 1);
    coreHang = 1'b0;
    applyStimulus(1, 16'd720);
    waitResponse(1, 16'd0, 16'h0000, 16'h4000, 1'b0, NORMAL_LAT);
`else
    begin
      int sawRsp;
      int notBusy;
      sawRsp  = 0;
      notBusy = 0;
      repeat (1000) begin
        @(negedge clk);
        if (rspValid) sawRsp++;
        if (!busy) notBusy++;
      end
      checkOutput("hang_no_response", 32'(sawRsp), 32'd0);
      checkOutput("hang_not_busy_cycles", 32'(notBusy), 32'd0);
    end
    reset    = 1'b1;
    coreHang = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 16'd720);
    waitResponse(1, 16'd0, 16'h0000, 16'h4000, 1'b0, NORMAL_LAT);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_req_arbiter.md
Name: cordic_req_arbiter

Overview:
- Shares one cordic_sin_cos core between N_REQ requesters.
- Round-robin arbitration; req/ack request handshake; tagged one-cycle response.
- Reduces any 16-bit unsigned degree input modulo 360 before issuing it to the core.
- Generates the core's start pulse, detects completion, and returns sine/cosine with the requester ID.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= N_REQ.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- req_angle  in  16*N_REQ  per-requester angle, unsigned degrees 0..65535; slice i is [16*i+15:16*i].
- ack  out  N_REQ  one-cycle pulse; request i accepted and angle latched.
- busy  out  1  high in any state except IDLE.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  ID_W  index of the requester owning the result.
- rsp_sine  out  16  signed Q2.14 sine.
- rsp_cosine  out  16  signed Q2.14 cosine.
- rsp_err  out  1  result invalid (timeout); qualified by rsp_valid.
- core_start  out  1  start pulse to the core.
- core_angle  out  16  degrees 0..359 to the core; held stable from ISSUE through WAIT.
- core_sine  in  16  core sine output.
- core_cosine  in  16  core cosine output.
- core_done  in  1  core done level.

Behaviour:
- Reset (async, immediate): state=IDLE; rr_ptr=N_REQ-1; all outputs 0.
  - A mid-operation reset abandons the transaction. No response and no ack are emitted.
  - The first IDLE cycle after release accepts requests normally.
- Registered state: state, rr_ptr, grant_id, work angle (16b), norm step k (3b), blank flag, watchdog counter.
- IDLE:
  - Search req starting at index rr_ptr+1, wrapping modulo N_REQ; the first asserted bit wins.
  - On a winner: pulse ack[winner] this cycle; latch angle and grant_id; rr_ptr<=winner; k<=7; go to NORM.
  - With no requests, stay in IDLE.
- Handshake rules:
  - A requester holds req and its angle until ack. Dropping req before ack withdraws the request.
  - req still high after ack is treated as a new request at the next IDLE.
- NORM: exactly 8 cycles, k=7 down to 0.
  - Each cycle: if angle >= (360<<k), angle <= angle - (360<<k). The compare is unsigned 17-bit; 360<<7 = 46080.
  - After k=0 the remainder is in 0..359, so 360 maps to 0. Go to ISSUE.
- ISSUE: 1 cycle. core_start=1 and core_angle=remainder. Clear blank flag and watchdog. Go to WAIT.
- WAIT:
  - The first cycle is a blanking cycle: core_done is ignored, because the core clears done only on accepting start.
  - From the second cycle on, core_done==1 means completion. Latch core_sine/core_cosine into rsp_sine/rsp_cosine, set rsp_err=0, go to RESP.
- RESP: 1 cycle. rsp_valid=1; rsp_id=grant_id; rsp_* hold the latched values. Go to IDLE.
  - rsp_* data remain stable until the next RESP.
  - No new ack is issued in the RESP cycle.
- Latency:
  - ack to rsp_valid = 8 NORM + 1 ISSUE + W WAIT + 1 RESP.
  - W is roughly 34 with the 16-iteration core. Minimum request-to-request turnaround is that value plus 1 IDLE cycle.
- Outputs are not combinationally dependent on core inputs; results are registered.
- Fairness: with all requests held high, grants rotate 0,1,...,N_REQ-1,0,...

Optional Feature:
- Macro: CORDIC_ARB_TIMEOUT_EN.
- Defined:
  - The watchdog counts WAIT cycles. On reaching TIMEOUT_CYCLES without completion, go to RESP with rsp_err=1 and rsp_sine=rsp_cosine=0.
  - core_start is not re-pulsed. The next transaction proceeds normally.
- Undefined:
  - No watchdog counter is synthesized; rsp_err is tied 0.
  - WAIT lasts until core_done, indefinitely if needed.

Test Plan:
- Single request: req[0] with angle 30 → ack[0] pulse in the IDLE cycle; core_angle=30; rsp_valid with rsp_id=0.
  - Expected values: sine ≈0x2000 and cosine ≈0x376D, each ±0x10.
- Modulo reduction:
  - angle 390 → core_angle=30, same result.
  - angle 720 → 0, giving sine ≈0x0000 and cosine ≈0x4000.
  - angle 65535 → 15.
  - angle 180 → sine 0x0000, cosine 0xC006.
- Arbitration: all 4 req held from reset → acks in order 0,1,2,3,0. Then with rr_ptr=3 and only req[1] and req[3] → grants 1 then 3.
- Withdrawal and reset:
  - req[2] dropped while busy → never acked.
  - reset asserted in WAIT → all outputs 0 immediately, no rsp_valid.
  - A new request after release completes correctly.
- Timeout (macro defined): core_done tied 0 → rsp_valid with rsp_err=1, 1 cycle after watchdog expiry (≈TIMEOUT_CYCLES+10 cycles after ack); the next request is acked.
- Timeout (macro undefined): same stimulus → busy stays 1 and no rsp_valid within 1000 cycles.
